alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_serial_ctrl_if.sv | 18 +
 rtl/alu_top.sv | 29 ++
 rtl/alu_serial_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_serial_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU controller: operand width,
// ALU operation codes and controller FSM state encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned IDX_W     = 5;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // AND/OR never report carry or overflow.
    function automatic logic is_logic_op(input alu_op_t op);
        return (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bundle of the bit-serial ALU controller.
interface alu_serial_ctrl_if;
    logic        start_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        cout_o;
    logic        overflow_o;

    modport master (output start_i, ctrl_i, src1_i, src2_i,
                    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o);
    modport slave  (input  start_i, ctrl_i, src1_i, src2_i,
                    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o);
endinterface

// File: rtl/alu_top.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less select.
module alu_top (
    input  logic       src1,
    input  logic       src2,
    input  logic       less,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout
);
    logic a_s;
    logic b_s;

    // Combinational slice datapath.
    always_comb begin
        a_s  = a_invert ? ~src1 : src1;
        b_s  = b_invert ? ~src2 : src2;
        cout = (a_s & b_s) | (a_s & cin) | (b_s & cin);
        case (operation)
            2'b00:   result = a_s & b_s;
            2'b01:   result = a_s | b_s;
            2'b10:   result = a_s ^ b_s ^ cin;
            2'b11:   result = less;
            default: result = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial 32-bit ALU: one alu_top slice iterated LSB first, then a fix-up cycle.
// Macro ALU_SERIAL_SIGNED_SLT_EN selects true signed SLT instead of raw sign of A-B.
module alu_serial_ctrl
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    alu_serial_ctrl_if.slave  bus
);
    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [ALU_WIDTH-1:0]   src1_r;
    logic [ALU_WIDTH-1:0]   src2_r;
    logic                   a_inv_r;
    logic                   b_inv_r;
    alu_op_t                op_r;
    logic                   carry_r;
    logic                   cin31_r;
    logic [ALU_WIDTH-1:0]   res_sr_r;
    logic [ALU_WIDTH-1:0]   result_r;
    logic                   zero_r;
    logic                   cout_r;
    logic                   ovf_r;
    logic                   busy_r;
    logic                   done_r;

    alu_op_t                slice_op_s;
    logic                   slice_res_s;
    logic                   slice_cout_s;
    logic                   ovf_s;
    logic                   set_s;
    logic [ALU_WIDTH-1:0]   final_s;

    alu_top u_slice (
        .src1      (src1_r[idx_r]),
        .src2      (src2_r[idx_r]),
        .less      (1'b0),
        .a_invert  (a_inv_r),
        .b_invert  (b_inv_r),
        .cin       (carry_r),
        .operation (slice_op_s),
        .result    (slice_res_s),
        .cout      (slice_cout_s)
    );

    // Slice op override and fix-up values; carry_r holds c_out31 once RUN ends.
    always_comb begin
        slice_op_s = (op_r == OP_SLT) ? OP_ADD : op_r;
        ovf_s      = cin31_r ^ carry_r;
`ifdef ALU_SERIAL_SIGNED_SLT_EN
        set_s      = res_sr_r[ALU_WIDTH-1] ^ ovf_s;
`else
        set_s      = res_sr_r[ALU_WIDTH-1];
`endif
        if (op_r == OP_SLT) begin
            final_s = {31'b0, set_s};
        end else begin
            final_s = res_sr_r;
        end
    end

    // Controller FSM with registered outputs; reset aborts any operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            idx_r    <= 5'd0;
            src1_r   <= 32'd0;
            src2_r   <= 32'd0;
            a_inv_r  <= 1'b0;
            b_inv_r  <= 1'b0;
            op_r     <= OP_AND;
            carry_r  <= 1'b0;
            cin31_r  <= 1'b0;
            res_sr_r <= 32'd0;
            result_r <= 32'd0;
            zero_r   <= 1'b0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        src1_r  <= bus.src1_i;
                        src2_r  <= bus.src2_i;
                        a_inv_r <= bus.ctrl_i[3];
                        b_inv_r <= bus.ctrl_i[2];
                        op_r    <= alu_op_t'(bus.ctrl_i[1:0]);
                        idx_r   <= 5'd0;
                        carry_r <= bus.ctrl_i[2];
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_sr_r[idx_r] <= slice_res_s;
                    carry_r         <= slice_cout_s;
                    if (idx_r == 5'd31) begin
                        cin31_r <= carry_r;
                        state_r <= ST_FIX;
                    end else begin
                        idx_r <= idx_r + 5'd1;
                    end
                end
                ST_FIX: begin
                    result_r <= final_s;
                    zero_r   <= (final_s == 32'd0);
                    cout_r   <= is_logic_op(op_r) ? 1'b0 : carry_r;
                    ovf_r    <= is_logic_op(op_r) ? 1'b0 : ovf_s;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o     = busy_r;
    assign bus.done_o     = done_r;
    assign bus.result_o   = result_r;
    assign bus.zero_o     = zero_r;
    assign bus.cout_o     = cout_r;
    assign bus.overflow_o = ovf_r;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl.
module tb_alu_serial_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_serial_ctrl_if bus();

    alu_serial_ctrl u_dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.ctrl_i = c; bus.src1_i = a; bus.src2_i = b;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk_i); #1;
            if (bus.done_o) begin lat = n; break; end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({bus.busy_o, bus.done_o, bus.zero_o, bus.cout_o, bus.overflow_o} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=00000",
                {bus.busy_o, bus.done_o, bus.zero_o, bus.cout_o, bus.overflow_o});
        end
        n_cmp++;
        if (bus.result_o !== 32'h0) begin
            n_bad++; $display("FAIL reset_result got=%h exp=00000000", bus.result_o);
        end
        @(negedge clk_i); rst_i = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        do_op(4'b0010, 32'd5, 32'd7, lat);
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL add_latency got=%0d exp=33", lat); end
        n_cmp++;
        if (bus.result_o !== 32'd12) begin n_bad++; $display("FAIL add_result got=%h exp=0000000c", bus.result_o); end
        n_cmp++;
        if ({bus.zero_o, bus.cout_o, bus.overflow_o, bus.busy_o} !== 4'b0000) begin
            n_bad++; $display("FAIL add_flags got=%b exp=0000",
                {bus.zero_o, bus.cout_o, bus.overflow_o, bus.busy_o});
        end
        @(posedge clk_i); #1;
        n_cmp++;
        if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse got=%b exp=0", bus.done_o); end
    endtask

    task automatic test_sub();
        int lat;
        do_op(4'b0110, 32'd3, 32'd5, lat);
        n_cmp++;
        if (bus.result_o !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sub_result got=%h exp=fffffffe", bus.result_o); end
        n_cmp++;
        if ({bus.zero_o, bus.cout_o, bus.overflow_o} !== 3'b000) begin
            n_bad++; $display("FAIL sub_flags got=%b exp=000", {bus.zero_o, bus.cout_o, bus.overflow_o});
        end
        // 7-7 = 0: zero set, no borrow means carry out 1
        do_op(4'b0110, 32'd7, 32'd7, lat);
        n_cmp++;
        if ({bus.result_o == 32'd0, bus.zero_o, bus.cout_o, bus.overflow_o} !== 4'b1110) begin
            n_bad++; $display("FAIL sub_zero got=%h/%b exp=00000000/110", bus.result_o,
                {bus.zero_o, bus.cout_o, bus.overflow_o});
        end
    endtask

    task automatic test_overflow();
        int lat;
        do_op(4'b0010, 32'h7FFF_FFFF, 32'd1, lat);
        n_cmp++;
        if (bus.result_o !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_result got=%h exp=80000000", bus.result_o); end
        n_cmp++;
        if ({bus.zero_o, bus.cout_o, bus.overflow_o} !== 3'b001) begin
            n_bad++; $display("FAIL ovf_flags got=%b exp=001", {bus.zero_o, bus.cout_o, bus.overflow_o});
        end
        do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, lat);
        n_cmp++;
        if ({bus.result_o == 32'd0, bus.zero_o, bus.cout_o, bus.overflow_o} !== 4'b1110) begin
            n_bad++; $display("FAIL carry_wrap got=%h/%b exp=00000000/110", bus.result_o,
                {bus.zero_o, bus.cout_o, bus.overflow_o});
        end
    endtask

    task automatic test_slt();
        int lat;
        logic [31:0] exp_v;
`ifdef ALU_SERIAL_SIGNED_SLT_EN
        exp_v = 32'd0;
`else
        exp_v = 32'd1;
`endif
        do_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, lat);
        n_cmp++;
        if (bus.result_o !== exp_v) begin n_bad++; $display("FAIL slt_edge got=%h exp=%h", bus.result_o, exp_v); end
        n_cmp++;
        if (bus.overflow_o !== 1'b1) begin n_bad++; $display("FAIL slt_ovf got=%b exp=1", bus.overflow_o); end
        do_op(4'b0111, 32'd2, 32'd9, lat);
        n_cmp++;
        if (bus.result_o !== 32'd1) begin n_bad++; $display("FAIL slt_small got=%h exp=00000001", bus.result_o); end
    endtask

    task automatic test_nor();
        int lat;
        do_op(4'b1100, 32'd0, 32'd0, lat);
        n_cmp++;
        if (bus.result_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL nor_result got=%h exp=ffffffff", bus.result_o); end
        n_cmp++;
        if ({bus.zero_o, bus.cout_o, bus.overflow_o} !== 3'b000) begin
            n_bad++; $display("FAIL nor_flags got=%b exp=000", {bus.zero_o, bus.cout_o, bus.overflow_o});
        end
        do_op(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, lat);
        n_cmp++;
        if (bus.result_o !== 32'hF0F0_0F0F) begin n_bad++; $display("FAIL or_result got=%h exp=f0f00f0f", bus.result_o); end
    endtask

    task automatic test_start_ignored();
        int dones;
        int first;
        dones = 0; first = -1;
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.ctrl_i = 4'b0010; bus.src1_i = 32'd5; bus.src2_i = 32'd7;
        @(posedge clk_i); #1;
        n_cmp++;
        if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL ign_busy got=%b exp=1", bus.busy_o); end
        @(negedge clk_i); bus.start_i = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (n == 10) begin
                @(negedge clk_i);
                bus.start_i = 1'b1; bus.ctrl_i = 4'b0001; bus.src1_i = 32'hAAAA_0000; bus.src2_i = 32'h1;
            end
            if (n == 11) begin @(negedge clk_i); bus.start_i = 1'b0; end
            @(posedge clk_i); #1;
            if (bus.done_o) begin dones++; if (first < 0) first = n; end
        end
        n_cmp++;
        if (dones !== 1 || first !== 33) begin
            n_bad++; $display("FAIL ign_single_done got=%0d@%0d exp=1@33", dones, first);
        end
        n_cmp++;
        if (bus.result_o !== 32'd12) begin n_bad++; $display("FAIL ign_result got=%h exp=0000000c", bus.result_o); end
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.ctrl_i = 4'b0010; bus.src1_i = 32'd100; bus.src2_i = 32'd1;
        @(posedge clk_i); #1;
        @(negedge clk_i); bus.start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b1; bus.start_i = 1'b1;
        @(posedge clk_i); #1;
        n_cmp++;
        if ({bus.busy_o, bus.done_o, bus.zero_o, bus.cout_o, bus.overflow_o} !== 5'b00000 ||
            bus.result_o !== 32'd0) begin
            n_bad++; $display("FAIL abort_outputs got=%b/%h exp=00000/00000000",
                {bus.busy_o, bus.done_o, bus.zero_o, bus.cout_o, bus.overflow_o}, bus.result_o);
        end
        @(negedge clk_i); rst_i = 1'b0; bus.start_i = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk_i); #1;
            if (bus.done_o) dones++;
        end
        n_cmp++;
        if (dones !== 0 || bus.busy_o !== 1'b0) begin
            n_bad++; $display("FAIL abort_no_done got=%0d/%b exp=0/0", dones, bus.busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int lat2;
        do_op(4'b0010, 32'd20, 32'd22, lat);
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'd42) begin
            n_bad++; $display("FAIL b2b_first got=%b/%h exp=1/0000002a", bus.done_o, bus.result_o);
        end
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.ctrl_i = 4'b0110; bus.src1_i = 32'd10; bus.src2_i = 32'd4;
        @(posedge clk_i); #1;
        n_cmp++;
        if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept got=%b%b exp=10", bus.busy_o, bus.done_o);
        end
        @(negedge clk_i); bus.start_i = 1'b0;
        lat2 = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk_i); #1;
            if (n == 20 && bus.result_o !== 32'd42) begin
                n_cmp++; n_bad++; $display("FAIL b2b_hold got=%h exp=0000002a", bus.result_o);
            end else if (n == 20) begin
                n_cmp++;
            end
            if (bus.done_o) begin lat2 = n; break; end
        end
        n_cmp++;
        if (lat2 !== 33 || bus.result_o !== 32'd6) begin
            n_bad++; $display("FAIL b2b_second got=%0d/%h exp=33/00000006", lat2, bus.result_o);
        end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.ctrl_i = 4'b0000; bus.src1_i = 32'd0; bus.src2_i = 32'd0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_slt();
        test_nor();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
